// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops FWFT FIFO bytes and sends them as back-to-back UART frames.
// Build with FIFO_UART_DRAIN_PARITY_EN defined for 8E1 frames; 8N1 otherwise.
module fifo_uart_drain #(
    parameter int G_CLK_PER_BIT = 8,
    parameter int G_COUNT_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [7:0]               i_data,
    input  logic                     i_data_empty,
    output logic                     o_data_rd,
    input  logic                     i_enable,
    output logic                     o_tx,
    output logic                     o_busy,
    output logic [G_COUNT_WIDTH-1:0] o_frame_count
);

    localparam int CW = $clog2(G_CLK_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(G_CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                   state, state_d;
    logic [CW-1:0]            cnt, cnt_d;
    logic [2:0]               idx, idx_d;
    logic [7:0]               sh, sh_d;
    logic [G_COUNT_WIDTH-1:0] count, count_d;
    logic                     tx, tx_d;
    logic                     rd;
    logic                     go;
    logic                     bit_end;
`ifdef FIFO_UART_DRAIN_PARITY_EN
    logic                     par;
`endif

    assign go        = i_enable && !i_data_empty;
    assign bit_end   = (cnt == LAST);
    assign o_data_rd = rd;
    assign o_tx      = tx;
    assign o_busy    = (state != IDLE);
    assign o_frame_count = count;

    // Next-state, pop decision and next line level.
    always_comb begin
        state_d = state;
        cnt_d   = bit_end ? '0 : cnt + 1'b1;
        idx_d   = idx;
        sh_d    = sh;
        count_d = count;
        rd      = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (go) begin
                    rd      = 1'b1;
                    sh_d    = i_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    sh_d = {1'b0, sh[7:1]};
                    if (idx == 3'd7) begin
`ifdef FIFO_UART_DRAIN_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end
            end
`ifdef FIFO_UART_DRAIN_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    count_d = count + 1'b1;
                    if (go) begin
                        rd      = 1'b1;
                        sh_d    = i_data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
`ifdef FIFO_UART_DRAIN_PARITY_EN
            PARITY:  tx_d = par;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State, counters, shift register and registered line output.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            count <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            sh    <= sh_d;
            count <= count_d;
            tx    <= tx_d;
        end
    end

`ifdef FIFO_UART_DRAIN_PARITY_EN
    // Even parity of the byte, captured when it is popped.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) par <= 1'b0;
        else if (rd)  par <= ^i_data;
    end
`endif

endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb_fifo_uart_drain: directed bench for fifo_uart_drain with G_CLK_PER_BIT=4.
// A queue stands in for the FWFT FIFO read side.
module tb_fifo_uart_drain;

    localparam int CPB = 4;
`ifdef FIFO_UART_DRAIN_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        i_data_empty = 1'b1;
    logic        o_data_rd;
    logic        i_enable = 1'b0;
    logic        o_tx;
    logic        o_busy;
    logic [15:0] o_frame_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];
    logic p;

    fifo_uart_drain #(.G_CLK_PER_BIT(CPB), .G_COUNT_WIDTH(16)) dut (
        .i_clk(clk),
        .i_rst_n(i_rst_n),
        .i_data(i_data),
        .i_data_empty(i_data_empty),
        .o_data_rd(o_data_rd),
        .i_enable(i_enable),
        .o_tx(o_tx),
        .o_busy(o_busy),
        .o_frame_count(o_frame_count)
    );

    always #5 clk = ~clk;

    // FIFO model: pop on a sampled strobe, then present the new head.
    always @(posedge clk) begin
        p = o_data_rd;
        #1;
        if (p && q.size() > 0) void'(q.pop_front());
        i_data_empty = (q.size() == 0);
        i_data = (q.size() > 0) ? q[0] : 8'h00;
    end

    task automatic do_reset();
        i_enable = 1'b0;
        q.delete();
        i_rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    task automatic wait_pop(input string nm);
        int n = 0;
        #1;
        while (!o_data_rd && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_data_rd !== 1'b1) begin
            errors++;
            $display("FAIL %s: no pop seen, o_data_rd=%b required 1", nm, o_data_rd);
        end
    endtask

    // Called at the pop negedge; samples the frame on the next FL negedges.
    task automatic check_frame(input string nm, input logic [7:0] b,
                               input logic par, input logic nxt,
                               input int drop_at);
        logic [FL-1:0] exp_v;
        logic [FL-1:0] got_v;
        int nbusy = 0;
        int extra = 0;
        for (int j = 0; j < FL; j++) begin
            int s = j / CPB;
            if (s == 0) exp_v[j] = 1'b0;
            else if (s <= 8) exp_v[j] = b[s-1];
            else if (s == 9 && NB == 11) exp_v[j] = par;
            else exp_v[j] = 1'b1;
        end
        for (int j = 0; j < FL; j++) begin
            @(negedge clk);
            if (drop_at == j + 1) i_enable = 1'b0;
            got_v[j] = o_tx;
            if (o_busy !== 1'b1) nbusy++;
            if (j < FL - 1 && o_data_rd !== 1'b0) extra++;
        end
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s frame: tx=%h required %h", nm, got_v, exp_v);
        end
        checks++;
        if (nbusy != 0 || extra != 0) begin
            errors++;
            $display("FAIL %s busy/pop: idle cycles=%0d extra pops=%0d required 0/0", nm, nbusy, extra);
        end
        checks++;
        if (o_data_rd !== nxt) begin
            errors++;
            $display("FAIL %s next pop: o_data_rd=%b required %b", nm, o_data_rd, nxt);
        end
    endtask

    task automatic check_count(input string nm, input logic [15:0] e);
        checks++;
        if (o_frame_count !== e) begin
            errors++;
            $display("FAIL %s count: o_frame_count=%0d required %0d", nm, o_frame_count, e);
        end
    endtask

    task automatic test_reset();
        int rds = 0;
        do_reset();
        checks++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_data_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: tx=%b busy=%b rd=%b required 1/0/0", o_tx, o_busy, o_data_rd);
        end
        check_count("reset", 16'd0);
        i_enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_data_rd !== 1'b0 || o_tx !== 1'b1 || o_busy !== 1'b0) rds++;
        end
        checks++;
        if (rds != 0) begin
            errors++;
            $display("FAIL empty idle: bad cycles=%0d required 0", rds);
        end
        check_count("empty idle", 16'd0);
    endtask

    task automatic test_single();
        do_reset();
        q.push_back(8'h55);
        @(negedge clk);
        @(negedge clk);
        i_enable = 1'b1;
        wait_pop("single");
        check_frame("single 55", 8'h55, 1'b0, 1'b0, 0);
        @(negedge clk);
        check_count("single", 16'd1);
        checks++;
        if (o_busy !== 1'b0 || o_tx !== 1'b1) begin
            errors++;
            $display("FAIL single idle: busy=%b tx=%b required 0/1", o_busy, o_tx);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        q.push_back(8'h00);
        q.push_back(8'hFF);
        q.push_back(8'hA3);
        @(negedge clk);
        @(negedge clk);
        i_enable = 1'b1;
        wait_pop("b2b");
        check_frame("b2b 00", 8'h00, 1'b0, 1'b1, 0);
        check_frame("b2b FF", 8'hFF, 1'b0, 1'b1, 0);
        check_frame("b2b A3", 8'hA3, 1'b0, 1'b0, 0);
        @(negedge clk);
        check_count("b2b", 16'd3);
    endtask

    task automatic test_enable_drop();
        int rds = 0;
        do_reset();
        q.push_back(8'h3C);
        q.push_back(8'hC3);
        @(negedge clk);
        @(negedge clk);
        i_enable = 1'b1;
        wait_pop("drop");
        check_frame("drop 3C", 8'h3C, 1'b0, 1'b0, 10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_data_rd !== 1'b0 || o_busy !== 1'b0) rds++;
        end
        checks++;
        if (rds != 0 || q.size() != 1) begin
            errors++;
            $display("FAIL drop hold: bad cycles=%0d queued=%0d required 0/1", rds, q.size());
        end
        i_enable = 1'b1;
        wait_pop("drop resume");
        check_frame("drop C3", 8'hC3, 1'b0, 1'b0, 0);
        @(negedge clk);
        check_count("drop", 16'd2);
    endtask

    task automatic test_reset_mid();
        do_reset();
        q.push_back(8'h11);
        q.push_back(8'h22);
        @(negedge clk);
        @(negedge clk);
        i_enable = 1'b1;
        wait_pop("rstmid");
        for (int i = 0; i < 12; i++) @(negedge clk);
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_data_rd !== 1'b1) begin
            errors++;
            $display("FAIL rstmid abort: tx=%b busy=%b rd=%b required 1/0/1", o_tx, o_busy, o_data_rd);
        end
        check_count("rstmid abort", 16'd0);
        check_frame("rstmid 22", 8'h22, 1'b0, 1'b0, 0);
        @(negedge clk);
        check_count("rstmid", 16'd1);
    endtask

`ifdef FIFO_UART_DRAIN_PARITY_EN
    task automatic test_parity();
        do_reset();
        q.push_back(8'h07);
        q.push_back(8'h03);
        @(negedge clk);
        @(negedge clk);
        i_enable = 1'b1;
        wait_pop("parity");
        check_frame("parity 07", 8'h07, 1'b1, 1'b1, 0);
        check_frame("parity 03", 8'h03, 1'b0, 1'b0, 0);
        @(negedge clk);
        check_count("parity", 16'd2);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
`ifdef FIFO_UART_DRAIN_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
